lsu_mem_ctrl: RTL and testbench

// - Initiator side of the word-wide data-memory port: the load/store unit between EX/MEM and data memory.
// - Accepts one RV32I load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
// - Converts byte addresses to word addresses and sign/zero-extends sub-word loads.
// - Sub-word stores are performed as read-modify-write, since the memory writes whole words only.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_mem_ctrl_if.sv | 41 ++++
 rtl/lsu_align.sv | 39 +++
 rtl/lsu_mem_ctrl.sv | 114 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-legality helpers for the load/store unit.
package lsu_pkg;

    // FSM state of the load/store controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // RV32I load/store width encodings (funct3).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal encodings: B/H/W for both directions, BU/HU for loads only.
    function automatic logic is_legal(input logic [2:0] funct3, input logic write);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even offset, words need offset 0; bytes are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-port bundle of the load/store unit.
//
// Handshake: a request transfers on the rising clk edge where req_valid and
// req_ready are both 1. The requester holds req_valid and all req_* fields
// stable until that edge. resp_valid is a single-cycle pulse with no
// backpressure; resp_err and resp_rdata are meaningful only while it is 1.
// The memory side has no handshake: mem_rdata is combinational from mem_addr
// while mem_read is 1, and the memory writes mem_wdata on the edge ending a
// cycle in which mem_write is 1.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // The load/store unit itself.
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    // The pipeline plus data memory surrounding it.
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extraction/extension and store byte-merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half out of the word and extend it to 32 bits.
    always_comb begin
        byte_v = 8'(word_i >> {off_i, 3'b000});
        half_v = 16'(word_i >> {off_i[1], 4'b0000});
        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_BU:   load_o = {24'h0, byte_v};
            F3_HU:   load_o = {16'h0, half_v};
            default: load_o = word_i;
        endcase
    end

    // Overlay only the addressed lane of the store data onto the captured word.
    always_comb begin
        store_o = word_i;
        case (funct3_i)
            F3_B:    store_o[{off_i, 3'b000} +: 8]      = wdata_i[7:0];
            F3_H:    store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            F3_W:    store_o = wdata_i;
            default: store_o = word_i;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one request at a time, word-wide memory port, RMW for sub-word stores.
// The bus interface must be instantiated with the same ADDR_W as this module.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W          = 6,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_ctrl_if.slave  bus,
    output lsu_state_e     dbg_state_o
);
    lsu_state_e        state_q, state_d;
    logic [2:0]        f3_q;
    logic              wr_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [1:0]        req_off;
    logic [31:0]       load_data;
    logic [31:0]       store_word;
    logic              unused_addr_hi;

    // Upper byte-address bits are outside the memory; addresses simply wrap.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    assign accept = (state_q == IDLE) && bus.req_valid;

    // Classify the incoming request and, in non-trapping mode, force alignment.
    always_comb begin
        req_err = ~is_legal(bus.req_funct3, bus.req_write) ||
                  (ERR_ON_MISALIGN && is_misaligned(bus.req_funct3, bus.req_addr[1:0]));
        req_off = bus.req_addr[1:0];
        if (!ERR_ON_MISALIGN) begin
            case (bus.req_funct3)
                F3_H, F3_HU: req_off[0] = 1'b0;
                F3_W:        req_off    = 2'b00;
                default:     req_off    = bus.req_addr[1:0];
            endcase
        end
    end

    // Next-state: loads and sub-word stores read first, SW goes straight to write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                      state_d = RESP;
                    else if (!bus.req_write)          state_d = RD;
                    else if (bus.req_funct3 == F3_W)  state_d = WR;
                    else                              state_d = RD;
                end
            end
            RD:      state_d = wr_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and the word captured at the end of RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            f3_q    <= 3'b000;
            wr_q    <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q    <= bus.req_funct3;
                wr_q    <= bus.req_write;
                off_q   <= req_off;
                waddr_q <= bus.req_addr[ADDR_W+1:2];
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
            end
            if (state_q == RD) begin
                word_q <= bus.mem_rdata;
            end
        end
    end

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .word_i   (word_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .store_o  (store_word)
    );

    // Port drivers, decoded from registered state only.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_read   = (state_q == RD);
    assign bus.mem_write  = (state_q == WR);
    assign bus.mem_addr   = waddr_q;
    assign bus.mem_wdata  = (state_q == WR) ? store_word : 32'h0;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = ((state_q == RESP) && !err_q && !wr_q) ? load_data : 32'h0;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: table of requests against a word memory model, plus
// hand sequences for reset-in-flight and the non-trapping misalignment mode.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [5:0]  maddr;
        logic [31:0] mwdata;
    } vec_t;

    logic clk;
    logic rst;
    logic preload;
    lsu_state_e dbg_state, dbg_state0;

    lsu_mem_ctrl_if #(.ADDR_W(6)) bus ();
    lsu_mem_ctrl_if #(.ADDR_W(6)) bus0 ();

    lsu_mem_ctrl #(.ADDR_W(6), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    lsu_mem_ctrl #(.ADDR_W(6), .ERR_ON_MISALIGN(1'b0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus0.slave),
        .dbg_state_o (dbg_state0)
    );

    // Clock and memory models
    logic [31:0] mem  [64];
    logic [31:0] mem0 [64];
    int          rd_cnt;
    int          wr_cnt;
    logic [5:0]  last_addr;
    logic [31:0] last_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata  = mem[bus.mem_addr];
    assign bus0.mem_rdata = mem0[bus0.mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]  = 32'h0;
                mem0[i] = 32'h0;
            end
            mem[0] = 32'd17;  mem[1] = 32'd9;  mem[2] = 32'd25;
            mem0[0] = 32'd17; mem0[1] = 32'd9; mem0[2] = 32'd25;
            rd_cnt = 0;
            wr_cnt = 0;
            last_addr = '0;
            last_wdata = '0;
        end else begin
            if (bus.mem_read) begin
                rd_cnt++;
                last_addr = bus.mem_addr;
            end
            if (bus.mem_write) begin
                wr_cnt++;
                last_addr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
                mem[bus.mem_addr] = bus.mem_wdata;
            end
        end
    end

    always @(posedge clk) begin
        assert (!(bus.mem_read && bus.mem_write)) else $error("mem_read and mem_write both high");
        assert (!(bus0.mem_read && bus0.mem_write)) else $error("mem_read and mem_write both high (dut0)");
    end

    // Scoreboard and check helpers
    logic [32:0] exp_q [$];
    int          pass_cnt;
    int          chk_cnt;
    vec_t        vecs [32];
    int          nvec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input int nrd, input int nwr, input logic [5:0] maddr,
                       input logic [31:0] mwdata);
        vecs[nvec] = '{name, wr, f3, addr, wdata, err, rdata, lat, nrd, nwr, maddr, mwdata};
        nvec++;
    endtask

    // Drive one request on the trapping DUT and score its response and memory traffic.
    task automatic do_req(input vec_t v);
        int          lat;
        int          n;
        int          rd0;
        int          wr0;
        logic [32:0] exp;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        exp_q.push_back({v.err, v.rdata});
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        exp = exp_q.pop_front();
        if (!bus.resp_valid) begin
            check({v.name, "_timeout"}, 32'(bus.resp_valid), 32'd1);
        end else begin
            check({v.name, "_rdata"}, bus.resp_rdata, exp[31:0]);
            check({v.name, "_err"}, 32'(bus.resp_err), 32'(exp[32]));
            check({v.name, "_lat"}, 32'(lat), 32'(v.lat));
            check({v.name, "_nrd"}, 32'(rd_cnt - rd0), 32'(v.nrd));
            check({v.name, "_nwr"}, 32'(wr_cnt - wr0), 32'(v.nwr));
            if (v.nrd + v.nwr > 0) check({v.name, "_maddr"}, 32'(last_addr), 32'(v.maddr));
            if (v.nwr > 0) check({v.name, "_mwdata"}, last_wdata, v.mwdata);
        end
    endtask

    // Drive one load on the non-trapping DUT.
    task automatic req0(input string name, input logic [2:0] f3, input logic [31:0] addr,
                        input logic err, input logic [31:0] rdata, input int exp_lat);
        int lat;
        @(negedge clk);
        bus0.req_valid  = 1'b1;
        bus0.req_write  = 1'b0;
        bus0.req_funct3 = f3;
        bus0.req_addr   = addr;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        lat = 1;
        while (!bus0.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, bus0.resp_rdata, rdata);
        check({name, "_err"}, 32'(bus0.resp_err), 32'(err));
    endtask

    // Main sequence
    initial begin
        vec_t v;
        int   w;
        logic [31:0] d;
        int   wr0;
        pass_cnt = 0;
        chk_cnt  = 0;
        nvec     = 0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_funct3 = 3'b0;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        preload = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b0;

        // Reset values
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp", {29'h0, bus.resp_valid, bus.resp_err, 1'b0}, 32'h0);
        check("rst_mem_rw", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        //   name      wr    f3     addr          wdata         err   rdata         lat rd wr maddr mwdata
        add("lw_4",    1'b0, F3_W,  32'h4,        32'h0,        1'b0, 32'd9,        2, 1, 0, 6'd1,  32'h0);
        add("sb_9",    1'b1, F3_B,  32'h9,        32'hAB,       1'b0, 32'h0,        3, 1, 1, 6'd2,  32'h0000AB19);
        add("lb_9",    1'b0, F3_B,  32'h9,        32'h0,        1'b0, 32'hFFFFFFAB, 2, 1, 0, 6'd2,  32'h0);
        add("lbu_9",   1'b0, F3_BU, 32'h9,        32'h0,        1'b0, 32'h000000AB, 2, 1, 0, 6'd2,  32'h0);
        add("sh_a",    1'b1, F3_H,  32'hA,        32'h8001,     1'b0, 32'h0,        3, 1, 1, 6'd2,  32'h8001AB19);
        add("lh_a",    1'b0, F3_H,  32'hA,        32'h0,        1'b0, 32'hFFFF8001, 2, 1, 0, 6'd2,  32'h0);
        add("lhu_a",   1'b0, F3_HU, 32'hA,        32'h0,        1'b0, 32'h00008001, 2, 1, 0, 6'd2,  32'h0);
        add("lhu_8",   1'b0, F3_HU, 32'h8,        32'h0,        1'b0, 32'h0000AB19, 2, 1, 0, 6'd2,  32'h0);
        add("lw_8",    1'b0, F3_W,  32'h8,        32'h0,        1'b0, 32'h8001AB19, 2, 1, 0, 6'd2,  32'h0);
        add("lh_3",    1'b0, F3_H,  32'h3,        32'h0,        1'b1, 32'h0,        1, 0, 0, 6'd0,  32'h0);
        add("sw_fc",   1'b1, F3_W,  32'hFC,       32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 6'd63, 32'hDEADBEEF);
        add("lw_fc",   1'b0, F3_W,  32'hFC,       32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, 6'd63, 32'h0);
        add("lb_fc",   1'b0, F3_B,  32'hFC,       32'h0,        1'b0, 32'hFFFFFFEF, 2, 1, 0, 6'd63, 32'h0);
        add("lhu_fe",  1'b0, F3_HU, 32'hFE,       32'h0,        1'b0, 32'h0000DEAD, 2, 1, 0, 6'd63, 32'h0);
        add("sw_100",  1'b1, F3_W,  32'h100,      32'h12345678, 1'b0, 32'h0,        2, 0, 1, 6'd0,  32'h12345678);
        add("lw_0",    1'b0, F3_W,  32'h0,        32'h0,        1'b0, 32'h12345678, 2, 1, 0, 6'd0,  32'h0);
        add("sb_103",  1'b1, F3_B,  32'h103,      32'h5A,       1'b0, 32'h0,        3, 1, 1, 6'd0,  32'h5A345678);
        add("lb_3",    1'b0, F3_B,  32'h3,        32'h0,        1'b0, 32'h0000005A, 2, 1, 0, 6'd0,  32'h0);
        add("lh_2",    1'b0, F3_H,  32'h2,        32'h0,        1'b0, 32'h00005A34, 2, 1, 0, 6'd0,  32'h0);
        add("lw_2",    1'b0, F3_W,  32'h2,        32'h0,        1'b1, 32'h0,        1, 0, 0, 6'd0,  32'h0);
        add("lhu_1",   1'b0, F3_HU, 32'h1,        32'h0,        1'b1, 32'h0,        1, 0, 0, 6'd0,  32'h0);
        add("ld_f011", 1'b0, 3'b011, 32'h0,       32'h0,        1'b1, 32'h0,        1, 0, 0, 6'd0,  32'h0);
        add("st_f100", 1'b1, 3'b100, 32'h0,       32'h77,       1'b1, 32'h0,        1, 0, 0, 6'd0,  32'h0);
        add("st_f110", 1'b1, 3'b110, 32'h0,       32'h77,       1'b1, 32'h0,        1, 0, 0, 6'd0,  32'h0);
        add("sb_8_hi", 1'b1, F3_B,  32'h8,        32'hFFFFFF12, 1'b0, 32'h0,        3, 1, 1, 6'd2,  32'h8001AB12);
        add("lw_8b",   1'b0, F3_W,  32'h8,        32'h0,        1'b0, 32'h8001AB12, 2, 1, 0, 6'd2,  32'h0);
        add("lw_0b",   1'b0, F3_W,  32'h0,        32'h0,        1'b0, 32'h5A345678, 2, 1, 0, 6'd0,  32'h0);

        for (int i = 0; i < nvec; i++) do_req(vecs[i]);

        // Reset pulsed while an SH is in its RD cycle
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_H;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h1234;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_in_rd", 32'(dbg_state), 32'(RD));
        wr0 = wr_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rw", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check("mid_rst_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'h0);
        check("mid_rst_wdata", bus.mem_wdata, 32'h0);
        check("mid_rst_rdata", bus.resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("mid_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("mid_word1", mem[1], 32'd9);
        v = '{"lw_4_after", 1'b0, F3_W, 32'h4, 32'h0, 1'b0, 32'd9, 2, 1, 0, 6'd1, 32'h0};
        do_req(v);

        // Random word stores with read-back
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(3, 62);
            d = $urandom;
            v = '{"rnd_sw", 1'b1, F3_W, 32'(w * 4), d, 1'b0, 32'h0, 2, 0, 1, 6'(w), d};
            do_req(v);
            v = '{"rnd_lw", 1'b0, F3_W, 32'(w * 4), 32'h0, 1'b0, d, 2, 1, 0, 6'(w), 32'h0};
            do_req(v);
        end

        // Non-trapping misalignment: low bits forced to alignment
        req0("nt_lh_3", F3_H, 32'h3, 1'b0, 32'h0, 2);
        req0("nt_lh_1", F3_H, 32'h1, 1'b0, 32'd17, 2);
        req0("nt_lw_6", F3_W, 32'h6, 1'b0, 32'd9, 2);
        req0("nt_ill", 3'b011, 32'h0, 1'b1, 32'h0, 1);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
